ex_issue_stage: RTL and testbench

EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

---
 rtl/alu_pkg.sv | 21 ++
 rtl/fwd_mux.sv | 31 +++
 rtl/ex_issue_stage.sv | 101 ++++++++++
 tb/tb_ex_issue_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath widths and the ALU operation encoding.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SLL   = 4'd1,
        SLT   = 4'd2,
        SLTU  = 4'd3,
        XOR   = 4'd4,
        SRL   = 4'd5,
        SRA   = 4'd6,
        OR    = 4'd7,
        AND   = 4'd8,
        SUB   = 4'd9,
        PASSB = 4'd10
    } alu_op_t;

endpackage

// File: rtl/fwd_mux.sv
// Bypass select for one source operand: the MEM result beats the WB result, and x0 is never bypassed.
module fwd_mux #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs_addr,
    input  logic [XLEN-1:0]  rs_data,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wr,
    input  logic [XLEN-1:0]  mem_data,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  fwd_data
);

    logic rs_nz;
    logic mem_hit;
    logic wb_hit;

    assign rs_nz   = (rs_addr != '0);
    assign mem_hit = rs_nz && mem_wr && (mem_rd == rs_addr);
    assign wb_hit  = rs_nz && wb_wr && (wb_rd == rs_addr);

    always_comb begin
        fwd_data = rs_data;
        if (mem_hit)     fwd_data = mem_data;
        else if (wb_hit) fwd_data = wb_data;
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with operand bypass, load-use interlock, backpressure hold and flush.
module ex_issue_stage import alu_pkg::*; #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int REG_W = alu_pkg::REG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [REG_W-1:0] id_rs1_addr,
    input  logic [REG_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_sel_a,
    input  logic             id_sel_b,
    input  logic [3:0]       id_alu_op,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_wr,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             ex_ready,
    input  logic [REG_W-1:0] fwd_mem_rd,
    input  logic             fwd_mem_wr,
    input  logic [XLEN-1:0]  fwd_mem_data,
    input  logic [REG_W-1:0] fwd_wb_rd,
    input  logic             fwd_wb_wr,
    input  logic [XLEN-1:0]  fwd_wb_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [3:0]       ex_alu_op,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_reg_wr,
    output logic             ex_is_load,
    output logic             load_use_stall
);

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            xfer;
    logic            rd_match;

    fwd_mux #(.XLEN(XLEN), .REG_W(REG_W)) u_fwd_rs1 (
        .rs_addr (id_rs1_addr), .rs_data (id_rs1_data),
        .mem_rd  (fwd_mem_rd),  .mem_wr  (fwd_mem_wr), .mem_data (fwd_mem_data),
        .wb_rd   (fwd_wb_rd),   .wb_wr   (fwd_wb_wr),  .wb_data  (fwd_wb_data),
        .fwd_data(rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REG_W(REG_W)) u_fwd_rs2 (
        .rs_addr (id_rs2_addr), .rs_data (id_rs2_data),
        .mem_rd  (fwd_mem_rd),  .mem_wr  (fwd_mem_wr), .mem_data (fwd_mem_data),
        .wb_rd   (fwd_wb_rd),   .wb_wr   (fwd_wb_wr),  .wb_data  (fwd_wb_data),
        .fwd_data(rs2_fwd)
    );

    // A load result is not ready until after MEM, so a dependent instruction must wait one cycle.
    assign rd_match       = (ex_rd == id_rs1_addr) || (ex_rd == id_rs2_addr);
    assign load_use_stall = ex_valid && ex_is_load && ex_reg_wr && (ex_rd != '0) && rd_match && id_valid;
    assign id_ready       = (!ex_valid || ex_ready) && !load_use_stall;
    assign xfer           = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_reg_wr     <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_alu_op     <= 4'(ADD);
        end else begin
            // Operand fields move only when an instruction actually lands in the stage.
            if (xfer && !flush) begin
                ex_a          <= id_sel_a ? id_pc  : rs1_fwd;
                ex_b          <= id_sel_b ? id_imm : rs2_fwd;
                ex_store_data <= rs2_fwd;
                ex_alu_op     <= id_alu_op;
                ex_rd         <= id_rd;
            end
            if (flush) begin
                ex_valid   <= 1'b0;
                ex_reg_wr  <= 1'b0;
                ex_is_load <= 1'b0;
            end else if (xfer) begin
                ex_valid   <= 1'b1;
                ex_reg_wr  <= id_reg_wr;
                ex_is_load <= id_is_load;
            end else if (!ex_valid || ex_ready) begin
                ex_valid   <= 1'b0;
                ex_reg_wr  <= 1'b0;
                ex_is_load <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed and random checks of ex_issue_stage against a behavioural ID/EX model.
module tb_ex_issue_stage;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic             id_ready;
    logic [REG_W-1:0] id_rs1_addr, id_rs2_addr;
    logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_pc, id_imm;
    logic             id_sel_a, id_sel_b;
    logic [3:0]       id_alu_op;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_wr, id_is_load;
    logic             flush, ex_ready;
    logic [REG_W-1:0] fwd_mem_rd, fwd_wb_rd;
    logic             fwd_mem_wr, fwd_wb_wr;
    logic [XLEN-1:0]  fwd_mem_data, fwd_wb_data;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_a, ex_b, ex_store_data;
    logic [3:0]       ex_alu_op;
    logic [REG_W-1:0] ex_rd;
    logic             ex_reg_wr, ex_is_load, load_use_stall;

    int errors = 0;
    int checks = 0;

    // Reference state of the ID/EX register.
    logic             m_valid, m_wr, m_ld;
    logic [XLEN-1:0]  m_a, m_b, m_sd;
    logic [3:0]       m_op;
    logic [REG_W-1:0] m_rd;
    bit               m_known;

    ex_issue_stage #(.XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_pc(id_pc), .id_imm(id_imm), .id_sel_a(id_sel_a), .id_sel_b(id_sel_b),
        .id_alu_op(id_alu_op), .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
        .flush(flush), .ex_ready(ex_ready),
        .fwd_mem_rd(fwd_mem_rd), .fwd_mem_wr(fwd_mem_wr), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_rd(fwd_wb_rd), .fwd_wb_wr(fwd_wb_wr), .fwd_wb_data(fwd_wb_data),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [REG_W-1:0] a, input logic [XLEN-1:0] d);
        if (a != 0 && fwd_mem_wr && fwd_mem_rd == a) return fwd_mem_data;
        if (a != 0 && fwd_wb_wr && fwd_wb_rd == a)   return fwd_wb_data;
        return d;
    endfunction

    task automatic idle_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_pc = 0; id_imm = 0; id_sel_a = 0; id_sel_b = 0; id_alu_op = 0; id_rd = 0;
        id_reg_wr = 0; id_is_load = 0; flush = 0; ex_ready = 1;
        fwd_mem_rd = 0; fwd_mem_wr = 0; fwd_mem_data = 0;
        fwd_wb_rd = 0; fwd_wb_wr = 0; fwd_wb_data = 0;
    endtask

    // One clock: check handshake outputs against the model, advance the model, check the register.
    task automatic cycle();
        bit stall, rdy, xfer;
        #1;
        stall = m_valid && m_ld && m_wr && m_rd != 0 &&
                (m_rd == id_rs1_addr || m_rd == id_rs2_addr) && id_valid;
        rdy   = (!m_valid || ex_ready) && !stall;
        xfer  = id_valid && rdy;
        chk("load_use_stall", load_use_stall, stall);
        chk("id_ready", id_ready, rdy);
        if (reset) begin
            m_valid = 0; m_wr = 0; m_ld = 0; m_a = 0; m_b = 0; m_sd = 0; m_op = 0; m_rd = 0;
            m_known = 1;
        end else if (flush) begin
            m_valid = 0; m_wr = 0; m_ld = 0;
            if (xfer) m_known = 0;
        end else if (xfer) begin
            m_valid = 1; m_wr = id_reg_wr; m_ld = id_is_load;
            m_a  = id_sel_a ? id_pc : fwd(id_rs1_addr, id_rs1_data);
            m_b  = id_sel_b ? id_imm : fwd(id_rs2_addr, id_rs2_data);
            m_sd = fwd(id_rs2_addr, id_rs2_data);
            m_op = id_alu_op; m_rd = id_rd; m_known = 1;
        end else if (!m_valid || ex_ready) begin
            m_valid = 0; m_wr = 0; m_ld = 0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_reg_wr", ex_reg_wr, m_wr);
        chk("ex_is_load", ex_is_load, m_ld);
        if (m_valid || m_known) begin
            chk("ex_a", ex_a, m_a);
            chk("ex_b", ex_b, m_b);
            chk("ex_store_data", ex_store_data, m_sd);
            chk("ex_alu_op", ex_alu_op, m_op);
            chk("ex_rd", ex_rd, m_rd);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        cycle();
        chk("reset_alu_op", ex_alu_op, 0);
        chk("reset_valid", ex_valid, 0);
        reset = 0;

        // Basic transfer
        id_valid = 1; id_rs1_addr = 5; id_rs1_data = 3; id_sel_b = 1; id_imm = 7;
        id_alu_op = 0; id_rd = 1; id_reg_wr = 1;
        cycle();
        chk("basic_valid", ex_valid, 1);
        chk("basic_a", ex_a, 3);
        chk("basic_b", ex_b, 7);
        chk("basic_op", ex_alu_op, 0);

        // Forward priority and x0
        id_rs1_addr = 4; id_rs1_data = 32'h11; id_sel_b = 0; id_rs2_addr = 4; id_alu_op = 4'd12;
        fwd_mem_rd = 4; fwd_mem_wr = 1; fwd_mem_data = 32'hAA;
        fwd_wb_rd = 4; fwd_wb_wr = 1; fwd_wb_data = 32'hBB;
        cycle();
        chk("fwd_mem", ex_a, 32'hAA);
        chk("fwd_store_mem", ex_store_data, 32'hAA);
        chk("alu_op_unfiltered", ex_alu_op, 12);
        fwd_mem_wr = 0;
        cycle();
        chk("fwd_wb", ex_a, 32'hBB);
        id_rs1_addr = 0; fwd_mem_rd = 0; fwd_wb_rd = 0; fwd_mem_wr = 1;
        cycle();
        chk("fwd_x0", ex_a, 32'h11);
        idle_inputs();

        // Load-use interlock
        id_valid = 1; id_rd = 6; id_reg_wr = 1; id_is_load = 1;
        cycle();
        id_rs1_addr = 1; id_rs2_addr = 6; id_rd = 7; id_is_load = 0;
        #1;
        chk("lu_stall", load_use_stall, 1);
        chk("lu_ready", id_ready, 0);
        cycle();
        chk("lu_bubble", ex_valid, 0);
        cycle();
        chk("lu_accept_valid", ex_valid, 1);
        chk("lu_accept_rd", ex_rd, 7);

        // Backpressure
        ex_ready = 0; id_rd = 9; id_rs2_addr = 2; id_rs1_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_rd", ex_rd, 7);
        end
        ex_ready = 1;
        cycle();
        chk("bp_release_rd", ex_rd, 9);

        // Flush overrides a transfer
        flush = 1;
        cycle();
        chk("flush_valid", ex_valid, 0);
        flush = 0;

        // Reset in the middle of a load-use stall
        id_rd = 6; id_is_load = 1; id_reg_wr = 1;
        cycle();
        id_rs1_addr = 6; id_is_load = 0; id_rd = 3;
        reset = 1;
        cycle();
        chk("rst_valid", ex_valid, 0);
        chk("rst_a", ex_a, 0);
        chk("rst_rd", ex_rd, 0);
        reset = 0;
        cycle();

        // Random traffic with a narrow register range to provoke hazards and bypasses
        for (int n = 0; n < 500; n++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1_addr  = REG_W'($urandom_range(0, 7));
            id_rs2_addr  = REG_W'($urandom_range(0, 7));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_pc        = $urandom;
            id_imm       = $urandom;
            id_sel_a     = 1'($urandom);
            id_sel_b     = 1'($urandom);
            id_alu_op    = 4'($urandom);
            id_rd        = REG_W'($urandom_range(0, 7));
            id_reg_wr    = ($urandom_range(0, 3) != 0);
            id_is_load   = ($urandom_range(0, 2) == 0);
            ex_ready     = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            reset        = ($urandom_range(0, 49) == 0);
            fwd_mem_rd   = REG_W'($urandom_range(0, 7));
            fwd_mem_wr   = 1'($urandom);
            fwd_mem_data = $urandom;
            fwd_wb_rd    = REG_W'($urandom_range(0, 7));
            fwd_wb_wr    = 1'($urandom);
            fwd_wb_data  = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
